// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter in front of a single-port data memory.
//            Requester 0 is the CPU memory stage, requester 1 the loader.
//            One access is in flight at a time: IDLE (grant) -> ACCESS
//            (memory strobe) -> RESP (done pulse).
// Config   : `define MEM_ARB_RR_EN for round-robin arbitration of
//            simultaneous requests; otherwise requester 0 has fixed priority.
// Ports    : CLK, RST_N (async, active-low)
//            req0/1, we0/1, addr0/1, wdata0/1   - requester inputs
//            gnt0/1, done0/1, rdata0/1, err0/1  - requester outputs
//            mem_addr, mem_write_data, mem_write_flag, mem_read_flag,
//            mem_valM, mem_dmem_error          - data memory side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WID
`define DATA_WID 32
`endif

module mem_arbiter #(
    parameter int MEM_TOP = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [`DATA_WID-1:0] addr0,
    input  logic [`DATA_WID-1:0] addr1,
    input  logic [`DATA_WID-1:0] wdata0,
    input  logic [`DATA_WID-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [`DATA_WID-1:0] rdata0,
    output logic [`DATA_WID-1:0] rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic [`DATA_WID-1:0] mem_addr,
    output logic [`DATA_WID-1:0] mem_write_data,
    output logic                 mem_write_flag,
    output logic                 mem_read_flag,
    input  logic [`DATA_WID-1:0] mem_valM,
    input  logic                 mem_dmem_error
);

    localparam int              W        = `DATA_WID;
    localparam logic [W-1:0]    TOP_ADDR = W'(MEM_TOP);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       we_q;       // latched direction of the in-flight access
    logic       owner_q;    // requester that owns the in-flight access
    logic       any_req;
    logic       winner;     // 0 = requester 0, 1 = requester 1
    logic       grant;
    logic       addr_bad;
    logic       acc_err;

    assign any_req = req0 | req1;

`ifdef MEM_ARB_RR_EN
    // prio names the requester that wins the next tie; it always moves to
    // the requester that was not just granted.
    logic prio;

    assign winner = (req0 && req1) ? prio : req1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio <= 1'b0;
        end else if (grant) begin
            prio <= ~winner;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is silent.
    assign winner = ~req0;
`endif

    // Grant is combinational so it lands in the same cycle the request is
    // seen; RST_N gates it so no grant escapes while reset is held.
    assign grant = RST_N && (state == IDLE) && any_req;
    assign gnt0  = grant && !winner;
    assign gnt1  = grant &&  winner;

    assign addr_bad = (mem_addr > TOP_ADDR);
    assign acc_err  = addr_bad | mem_dmem_error;

    // Strobes decode from state only, so an asynchronous reset during
    // ACCESS drops them immediately.
    assign mem_write_flag = (state == ACCESS) &&  we_q && !addr_bad;
    assign mem_read_flag  = (state == ACCESS) && !we_q;

    assign done0 = (state == RESP) && !owner_q;
    assign done1 = (state == RESP) &&  owner_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            owner_q        <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            rdata0         <= '0;
            rdata1         <= '0;
            err0           <= 1'b0;
            err1           <= 1'b0;
        end else begin
            state <= state_nxt;

            // Latch the winner's request so later input changes cannot
            // disturb the access in flight.
            if (grant) begin
                owner_q        <= winner;
                we_q           <= winner ? we1    : we0;
                mem_addr       <= winner ? addr1  : addr0;
                mem_write_data <= winner ? wdata1 : wdata0;
            end

            // Capture the result at the edge leaving ACCESS; writes keep
            // the previous read data, faulted reads return zero.
            if (state == ACCESS) begin
                if (owner_q) begin
                    err1 <= acc_err;
                    if (!we_q) rdata1 <= acc_err ? '0 : mem_valM;
                end else begin
                    err0 <= acc_err;
                    if (!we_q) rdata0 <= acc_err ? '0 : mem_valM;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A cycle monitor predicts
//            grants, memory strobes and done pulses; grants push the
//            accepted request into a scoreboard that is popped and checked
//            when the matching done arrives. Scenario tasks add targeted
//            checks on memory contents and held outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WID
`define DATA_WID 32
`endif

module tb_mem_arbiter;

    localparam int           W        = `DATA_WID;
    localparam int           MEM_TOP  = 10;
    localparam logic [W-1:0] TOP_A    = W'(MEM_TOP);

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic         gnt0, gnt1, done0, done1, err0, err1;
    logic [W-1:0] rdata0, rdata1, mem_addr, mem_write_data, mem_valM;
    logic         mem_write_flag, mem_read_flag;
    logic         mem_dmem_error = 1'b0;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.MEM_TOP(MEM_TOP)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
        .mem_valM(mem_valM), .mem_dmem_error(mem_dmem_error)
    );

    always #5 CLK = ~CLK;

    // Data memory attached to the arbiter
    logic [W-1:0] dmem [0:15] = '{default: '0};
    always @(posedge CLK) begin
        if (mem_write_flag && mem_addr < 16) dmem[mem_addr[3:0]] <= mem_write_data;
    end
    assign mem_valM = (mem_addr < 16) ? dmem[mem_addr[3:0]] : '0;

    // Reference model state
    typedef struct {
        int           who;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic         derr;
    } acc_t;

    acc_t         sb[$];
    acc_t         cur;
    logic [W-1:0] ref_mem [0:15] = '{default: '0};
    logic [W-1:0] exp_rd [0:1] = '{default: '0};
    bit           gnt_prev = 0, acc_prev = 0, prio = 0;

    always @(negedge CLK) begin
        bit           acc_now, resp_now, ewf, erf, experr;
        logic [1:0]   exp_g, exp_d;
        acc_t         e;
        if (!RST_N) begin
            sb.delete();
            gnt_prev  = 0;
            acc_prev  = 0;
            prio      = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            acc_now  = gnt_prev;
            resp_now = acc_prev;

            exp_g = 2'b00;
            if (!acc_now && !resp_now) begin
                if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
                    exp_g = prio ? 2'b10 : 2'b01;
`else
                    exp_g = 2'b01;
`endif
                end else if (req0) exp_g = 2'b01;
                else if (req1)     exp_g = 2'b10;
            end
            checks++;
            if ({gnt1, gnt0} !== exp_g) begin
                failures++;
                $display("FAIL grant @%0t: got %b required %b", $time, {gnt1, gnt0}, exp_g);
            end

            ewf = acc_now && cur.we && (cur.addr <= TOP_A);
            erf = acc_now && !cur.we;
            checks++;
            if ({mem_write_flag, mem_read_flag} !== {ewf, erf}) begin
                failures++;
                $display("FAIL mem_flags @%0t: wr/rd got %b%b required %b%b",
                         $time, mem_write_flag, mem_read_flag, ewf, erf);
            end
            if (acc_now) begin
                checks++;
                if (mem_addr !== cur.addr || (cur.we && mem_write_data !== cur.wdata)) begin
                    failures++;
                    $display("FAIL mem_bus @%0t: addr/data got %0h/%0h required %0h/%0h",
                             $time, mem_addr, mem_write_data, cur.addr, cur.wdata);
                end
                if (sb.size() > 0) sb[sb.size()-1].derr = mem_dmem_error;
            end

            exp_d = resp_now ? ((cur.who == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({done1, done0} !== exp_d) begin
                failures++;
                $display("FAIL done @%0t: got %b required %b", $time, {done1, done0}, exp_d);
            end

            if (done0 || done1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty @%0t: done with no accepted request", $time);
                end else begin
                    e = sb.pop_front();
                    experr = (e.addr > TOP_A) || e.derr;
                    if (!e.we) exp_rd[e.who] = experr ? '0 : ref_mem[e.addr[3:0]];
                    else if (e.addr <= TOP_A) ref_mem[e.addr[3:0]] = e.wdata;
                    if (e.who == 0) begin
                        if (rdata0 !== exp_rd[0] || err0 !== experr) begin
                            failures++;
                            $display("FAIL resp0 @%0t: rdata/err got %0h/%b required %0h/%b",
                                     $time, rdata0, err0, exp_rd[0], experr);
                        end
                    end else begin
                        if (rdata1 !== exp_rd[1] || err1 !== experr) begin
                            failures++;
                            $display("FAIL resp1 @%0t: rdata/err got %0h/%b required %0h/%b",
                                     $time, rdata1, err1, exp_rd[1], experr);
                        end
                    end
                end
            end

            gnt_prev = 0;
            if (gnt0 || gnt1) begin
                cur.who   = gnt1 ? 1 : 0;
                cur.we    = gnt1 ? we1 : we0;
                cur.addr  = gnt1 ? addr1 : addr0;
                cur.wdata = gnt1 ? wdata1 : wdata0;
                cur.derr  = 1'b0;
                sb.push_back(cur);
                prio      = (cur.who == 0);
                gnt_prev  = 1;
            end
            acc_prev = acc_now;
        end
    end

    // Drive one request, hold it until granted, then wait out the access.
    task automatic do_access(input int who, input logic we, input logic [W-1:0] a,
                             input logic [W-1:0] d);
        bit got = 0;
        if (who == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else          begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            got = (who == 0) ? gnt0 : gnt1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL grant_timeout req%0d: gnt 0 required 1", who);
        end
        @(posedge CLK); #1;
        req0 = 0; req1 = 0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        req0 = 1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, mem_write_flag, mem_read_flag} !== 8'h00 ||
            rdata0 !== '0 || rdata1 !== '0 || mem_addr !== '0 || mem_write_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b%b done=%b%b err=%b%b flags=%b%b rdata=%0h/%0h addr=%0h wd=%0h required all 0",
                     gnt0, gnt1, done0, done1, err0, err1, mem_write_flag, mem_read_flag,
                     rdata0, rdata1, mem_addr, mem_write_data);
        end
        req0 = 0;
        RST_N = 1;
        @(posedge CLK); #1;
    endtask

    task automatic test_write();
        do_access(0, 1'b1, W'(3), W'(8'h55));
        checks++;
        if (dmem[3] !== W'(8'h55) || err0 !== 1'b0) begin
            failures++;
            $display("FAIL write_addr3: mem=%0h err0=%b required 55/0", dmem[3], err0);
        end
    endtask

    task automatic test_read();
        do_access(1, 1'b0, W'(3), '0);
        checks++;
        if (rdata1 !== W'(8'h55) || rdata0 !== '0) begin
            failures++;
            $display("FAIL read_addr3: rdata1=%0h rdata0=%0h required 55/0", rdata1, rdata0);
        end
    endtask

    task automatic test_addr_err();
        do_access(0, 1'b1, W'(11), W'(8'hAA));
        checks++;
        if (dmem[11] !== '0 || err0 !== 1'b1 || rdata0 !== '0) begin
            failures++;
            $display("FAIL write_addr11: mem=%0h err0=%b rdata0=%0h required 0/1/0", dmem[11], err0, rdata0);
        end
        do_access(0, 1'b0, W'(11), '0);
        checks++;
        if (err0 !== 1'b1 || rdata0 !== '0) begin
            failures++;
            $display("FAIL read_addr11: err0=%b rdata0=%0h required 1/0", err0, rdata0);
        end
    endtask

    task automatic test_dmem_err();
        mem_dmem_error = 1;
        do_access(1, 1'b0, W'(3), '0);
        mem_dmem_error = 0;
        checks++;
        if (err1 !== 1'b1 || rdata1 !== '0) begin
            failures++;
            $display("FAIL dmem_error_read: err1=%b rdata1=%0h required 1/0", err1, rdata1);
        end
        do_access(1, 1'b0, W'(3), '0);
        checks++;
        if (err1 !== 1'b0 || rdata1 !== W'(8'h55)) begin
            failures++;
            $display("FAIL reread_addr3: err1=%b rdata1=%0h required 0/55", err1, rdata1);
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        int exp_order[4];
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        req0 = 1; we0 = 0; addr0 = W'(3);
        req1 = 1; we1 = 0; addr1 = W'(3);
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            @(negedge CLK);
            if (gnt0) order.push_back(0);
            else if (gnt1) order.push_back(1);
        end
        @(posedge CLK); #1;
        req0 = 0; req1 = 0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: grants %0d required 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    failures++;
                    $display("FAIL b2b_order[%0d]: got req%0d required req%0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit got = 0;
        req0 = 1; we0 = 1; addr0 = W'(5); wdata0 = W'(8'h77);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            got = gnt0;
        end
        @(posedge CLK); #1;
        req0 = 0;
        checks++;
        if (!got || mem_write_flag !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: gnt=%b wr_flag=%b required 1/1", got, mem_write_flag);
        end
        #1 RST_N = 0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, mem_write_flag, mem_read_flag} !== 8'h00 ||
            rdata0 !== '0 || rdata1 !== '0 || mem_addr !== '0 || mem_write_data !== '0) begin
            failures++;
            $display("FAIL abort_outputs: wr_flag=%b done=%b%b rdata=%0h/%0h addr=%0h required all 0",
                     mem_write_flag, done0, done1, rdata0, rdata1, mem_addr);
        end
        @(posedge CLK); #1;
        RST_N = 1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (dmem[5] !== ref_mem[5]) begin
            failures++;
            $display("FAIL abort_mem5: mem=%0h required %0h", dmem[5], ref_mem[5]);
        end
    endtask

    task automatic test_hold_change();
        bit got = 0;
        req0 = 1; we0 = 1; addr0 = W'(7); wdata0 = W'(8'h3C);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            got = gnt0;
        end
        @(posedge CLK); #1;
        req0 = 0; we0 = 0; addr0 = W'(2); wdata0 = W'(8'h11);
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (!got || dmem[7] !== W'(8'h3C) || dmem[2] !== '0) begin
            failures++;
            $display("FAIL hold_change: gnt=%b mem7=%0h mem2=%0h required 1/3c/0", got, dmem[7], dmem[2]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_err();
        test_dmem_err();
        test_back_to_back();
        test_abort();
        test_hold_change();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d accesses without done required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
